// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Entry layout is what the fetch buffer stores: a pc paired with its instruction word.
package fetch_pkg;

    localparam int unsigned PC_W   = 27;
    localparam int unsigned INST_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Fetch is always word aligned; low address bits of a target are dropped.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding fetched (pc, inst) entries ahead of decode.
// Flush empties the queue and takes priority over push and pop on the same edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             flush,
    output entry_t           head,
    output logic [OCC_W-1:0] occ
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Guards keep the pointers coherent even if an upstream bug over-pushes.
    assign do_push = push && (occ_q != OCC_W'(DEPTH));
    assign do_pop  = pop && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!do_push && do_pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            occ_q <= occ_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the pc, absorbs the one-cycle imem latency and
// queues fetched words for decode; redirects flush all younger work.
module fetch_unit #(
    parameter logic [fetch_pkg::PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [fetch_pkg::PC_W-1:0] imem_pc,
    input  logic [31:0]                imem_inst,
    input  logic                       redirect_valid,
    input  logic [fetch_pkg::PC_W-1:0] redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [fetch_pkg::PC_W-1:0] out_pc,
    output logic [31:0]                out_inst
);
    import fetch_pkg::*;

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(BUF_DEPTH);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             pop, issue;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   committed;
    fetch_entry_t     head, push_data;

    assign imem_pc   = fetch_pc_q;
    assign out_valid = (occ != '0);
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign pop       = out_valid & out_ready;

    always_comb begin
        push_data      = '0;
        push_data.pc   = inflight_pc_q;
        push_data.inst = imem_inst;
    end

    // Credit check: slots already owned (buffered + in flight) after this cycle's pop.
    always_comb begin
        committed = {1'b0, occ} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
        issue     = !redirect_valid && (committed < DEPTH_C);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = pc_align(redirect_pc);
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A returning word is pushed unconditionally; a coincident redirect flush wins inside the FIFO.
    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a stream-level model of the expected pc sequence.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] imem_pc;
    logic [31:0]     imem_inst = '0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_inst;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(
        .RESET_PC  (27'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
        return 32'h1000_0000 + 32'(a >> 2);
    endfunction

    // Synchronous instruction memory: data for last cycle's address.
    always @(posedge clk) imem_inst <= word_at(imem_pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Stream model: decode must see consecutive words from the last restart point.
    logic [PC_W-1:0] exp_pc = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 27'h0;
        end else begin
            if (out_valid) begin
                check("model pc", 32'(out_pc), 32'(exp_pc));
                check("model inst", out_inst, word_at(exp_pc));
            end
            if (redirect_valid) exp_pc = redirect_pc & ~PC_W'(3);
            else if (out_valid && out_ready) exp_pc = exp_pc + PC_W'(4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        #12;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_pc", 32'(out_pc), 32'h0);
        check("rst out_inst", out_inst, 32'h0);
        check("rst imem_pc", 32'(imem_pc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] inst);
        check({name, " valid"}, 32'(out_valid), 32'h1);
        check({name, " pc"}, 32'(out_pc), pc);
        check({name, " inst"}, out_inst, inst);
    endtask

    task automatic pulse_redirect(input logic [PC_W-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Startup latency and streaming
        out_ready = 1'b1;
        do_reset();
        tick();
        check("s1 e1 valid", 32'(out_valid), 32'h0);
        check("s1 e1 imem_pc", 32'(imem_pc), 32'h4);
        tick();
        expect_out("s1 first", 32'h0, 32'h1000_0000);
        tick();
        expect_out("s1 second", 32'h4, 32'h1000_0001);
        tick();
        expect_out("s1 third", 32'h8, 32'h1000_0002);
        tick();
        expect_out("s1 fourth", 32'hc, 32'h1000_0003);

        // Backpressure after first delivery
        do_reset();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("s2 hold", 32'h0, 32'h1000_0000);
            check("s2 imem_pc stall", 32'(imem_pc), 32'h8);
        end
        out_ready = 1'b1;
        tick();
        expect_out("s2 rel 4", 32'h4, 32'h1000_0001);
        tick();
        expect_out("s2 rel 8", 32'h8, 32'h1000_0002);
        tick();
        expect_out("s2 rel c", 32'hc, 32'h1000_0003);

        // Redirect with a full buffer, misaligned target
        out_ready = 1'b0;
        tick();
        tick();
        pulse_redirect(27'h103);
        check("s3 valid after redirect", 32'(out_valid), 32'h0);
        check("s3 imem_pc target", 32'(imem_pc), 32'h100);
        out_ready = 1'b1;
        tick();
        check("s3 bubble", 32'(out_valid), 32'h0);
        tick();
        expect_out("s3 target", 32'h100, 32'h1000_0040);
        tick();
        expect_out("s3 target+4", 32'h104, 32'h1000_0041);

        // Redirect coincident with pop of pc 8
        do_reset();
        repeat (4) tick();
        expect_out("s4 pc8", 32'h8, 32'h1000_0002);
        pulse_redirect(27'h40);
        check("s4 valid after redirect", 32'(out_valid), 32'h0);
        check("s4 imem_pc target", 32'(imem_pc), 32'h40);
        tick();
        check("s4 bubble", 32'(out_valid), 32'h0);
        tick();
        expect_out("s4 target", 32'h40, 32'h1000_0010);
        tick();
        expect_out("s4 target+4", 32'h44, 32'h1000_0011);

        // Back-to-back redirects: last wins
        redirect_valid = 1'b1;
        redirect_pc    = 27'h200;
        tick();
        pulse_redirect(27'h300);
        check("s5 valid", 32'(out_valid), 32'h0);
        check("s5 imem_pc", 32'(imem_pc), 32'h300);
        tick();
        tick();
        expect_out("s5 target", 32'h300, 32'h1000_00c0);

        // Address wrap
        pulse_redirect(27'h7FF_FFFC);
        tick();
        tick();
        expect_out("s6 top", 32'h7FF_FFFC, 32'h11FF_FFFF);
        tick();
        expect_out("s6 wrap", 32'h0, 32'h1000_0000);
        tick();
        expect_out("s6 wrap+4", 32'h4, 32'h1000_0001);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("s7 async valid", 32'(out_valid), 32'h0);
        check("s7 async imem_pc", 32'(imem_pc), 32'h0);
        check("s7 async out_pc", 32'(out_pc), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("s7 e1 valid", 32'(out_valid), 32'h0);
        check("s7 e1 imem_pc", 32'(imem_pc), 32'h4);
        tick();
        expect_out("s7 first", 32'h0, 32'h1000_0000);
        tick();
        expect_out("s7 second", 32'h4, 32'h1000_0001);
        tick();
        expect_out("s7 third", 32'h8, 32'h1000_0002);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
